// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for an N-digit common-anode
// seven-segment display. Digits are shadowed on Load, scanned one per refresh
// slot, and decoded to active-low hex glyphs. Each slot opens with a short
// dead time to stop ghosting. Digits can be blanked per digit, by leading-zero
// suppression, or by a per-digit blink.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Load,
    input  logic [4*NUM_DIGITS-1:0] Digits,
    input  logic [NUM_DIGITS-1:0]   Ghost,
    input  logic [NUM_DIGITS-1:0]   Blink,
    input  logic                    Lz_En,
    output logic [0:6]              Seg,
    output logic [NUM_DIGITS-1:0]   An,
    output logic                    Frame
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] BLANK_END = PRE_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]      pre;
    logic [IDX_W-1:0]      idx;
    logic [FRM_W-1:0]      frm_cnt;
    logic                  phase;
    logic [3:0]            digit_reg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] ghost_reg;
    logic [NUM_DIGITS-1:0] blink_reg;

    logic                  pre_wrap;
    logic                  frame_wrap;
    logic [3:0]            cur_digit;
    logic                  lz_blank;
    logic                  blank;
    logic [0:6]            glyph;
    logic [NUM_DIGITS-1:0] an_active;

    assign pre_wrap   = (pre == PRE_LAST);
    assign frame_wrap = pre_wrap && (idx == IDX_LAST);

    // Shadow registers: capture the whole digit set at once so the display
    // never shows a half-updated value.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_reg[i] <= 4'h0;
            end
            ghost_reg <= '0;
            blink_reg <= '0;
        end else if (Load) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_reg[i] <= Digits[4*i +: 4];
            end
            ghost_reg <= Ghost;
            blink_reg <= Blink;
        end
    end

    // Slot prescaler, digit index and blink frame counter; the blink phase
    // flips on the same edge that raises Frame.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pre     <= '0;
            idx     <= '0;
            frm_cnt <= '0;
            phase   <= 1'b0;
        end else begin
            if (pre_wrap) begin
                pre <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
            if (frame_wrap) begin
                if (frm_cnt == FRM_LAST) begin
                    frm_cnt <= '0;
                    phase   <= ~phase;
                end else begin
                    frm_cnt <= frm_cnt + 1'b1;
                end
            end
        end
    end

    // Current digit selection, blanking decision and hex glyph decode.
    always_comb begin
        cur_digit = digit_reg[idx];
        lz_blank  = 1'b0;
        if (Lz_En && (idx != '0)) begin
            lz_blank = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if ((i >= int'(idx)) && (digit_reg[i] != 4'h0)) begin
                    lz_blank = 1'b0;
                end
            end
        end
        blank     = ghost_reg[idx] || (blink_reg[idx] && phase) || lz_blank;
        an_active = ~(NUM_DIGITS'(1) << idx);
        glyph     = 7'b1111111;
        case (cur_digit)
            4'h0:    glyph = 7'b0000001;
            4'h1:    glyph = 7'b1001111;
            4'h2:    glyph = 7'b0010010;
            4'h3:    glyph = 7'b0000110;
            4'h4:    glyph = 7'b1001100;
            4'h5:    glyph = 7'b0100100;
            4'h6:    glyph = 7'b0100000;
            4'h7:    glyph = 7'b0001111;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0000100;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b1100000;
            4'hC:    glyph = 7'b0110001;
            4'hD:    glyph = 7'b1000010;
            4'hE:    glyph = 7'b0110000;
            4'hF:    glyph = 7'b0111000;
            default: glyph = 7'b1111111;
        endcase
    end

    // Registered pin drivers: dead time at the start of a slot, then one
    // anode low with its glyph (or all segments off when blanked).
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Seg   <= 7'b1111111;
            An    <= '1;
            Frame <= 1'b0;
        end else begin
            Frame <= frame_wrap;
            if (pre < BLANK_END) begin
                Seg <= 7'b1111111;
                An  <= '1;
            end else begin
                Seg <= blank ? 7'b1111111 : glyph;
                An  <= an_active;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed checks of scan timing, glyph decode,
// leading-zero suppression, ghost/blink blanking, async reset and shadow load.
module tb_seven_seg_scanner;

    localparam int ND    = 4;
    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int BF    = 2;

    localparam logic [0:6] G_OFF = 7'b1111111;
    localparam logic [0:6] G0    = 7'b0000001;
    localparam logic [0:6] G1    = 7'b1001111;
    localparam logic [0:6] G2    = 7'b0010010;
    localparam logic [0:6] G3    = 7'b0000110;
    localparam logic [0:6] G5    = 7'b0100100;
    localparam logic [0:6] G8    = 7'b0000000;
    localparam logic [0:6] GA    = 7'b0001000;
    localparam logic [0:6] GF    = 7'b0111000;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Load;
    logic [15:0]   Digits;
    logic [3:0]    Ghost;
    logic [3:0]    Blink;
    logic          Lz_En;
    logic [0:6]    Seg;
    logic [3:0]    An;
    logic          Frame;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    seven_seg_scanner #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (DIV),
        .BLANK_CYCLES(BLANK),
        .BLINK_FRAMES(BF)
    ) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Load  (Load),
        .Digits(Digits),
        .Ghost (Ghost),
        .Blink (Blink),
        .Lz_En (Lz_En),
        .Seg   (Seg),
        .An    (An),
        .Frame (Frame)
    );

    // Free-running 10-unit clock.
    always #5 Clk = ~Clk;

    // Watchdog so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    // Advance one rising edge and sample just after it; cyc counts edges since
    // the last reset release.
    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    // Output at edge k reflects the slot state before that edge.
    function automatic int slot_pre(int k);
        return (k - 1) % DIV;
    endfunction

    function automatic int slot_idx(int k);
        return ((k - 1) / DIV) % ND;
    endfunction

    function automatic logic [3:0] exp_an(int k);
        logic [3:0] one;
        one = 4'b0001;
        if (slot_pre(k) < BLANK) return 4'b1111;
        return ~(one << slot_idx(k));
    endfunction

    function automatic logic exp_frame(int k);
        return (k % (DIV * ND)) == 0;
    endfunction

    task automatic do_reset();
        Rst = 1'b1;
        tick();
        tick();
        Rst = 1'b0;
        cyc = 0;
    endtask

    task automatic load_shadow(input logic [15:0] d, input logic [3:0] g, input logic [3:0] b);
        Digits = d;
        Ghost  = g;
        Blink  = b;
        Load   = 1'b1;
        tick();
        Load   = 1'b0;
    endtask

    task automatic test_reset();
        logic [0:6] es;
        Load = 1'b0; Digits = '0; Ghost = '0; Blink = '0; Lz_En = 1'b0;
        Rst = 1'b1;
        tick();
        tick();
        checks++;
        if (Seg !== G_OFF || An !== 4'b1111 || Frame !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_values got Seg=%b An=%b Frame=%b expected Seg=%b An=1111 Frame=0",
                     Seg, An, Frame, G_OFF);
        end
        Rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            es = (slot_pre(cyc) < BLANK) ? G_OFF : G0;
            checks++;
            if (An !== exp_an(cyc) || Seg !== es || Frame !== exp_frame(cyc)) begin
                failures++;
                $display("[TB] FAIL reset_scan cyc=%0d got An=%b Seg=%b Frame=%b expected An=%b Seg=%b Frame=%b",
                         cyc, An, Seg, Frame, exp_an(cyc), es, exp_frame(cyc));
            end
        end
    endtask

    task automatic test_hex_glyphs();
        logic [0:6] eg [4];
        logic [0:6] es;
        eg = '{GF, G3, GA, G1};
        Lz_En = 1'b0;
        load_shadow(16'h1A3F, 4'b0000, 4'b0000);
        for (int i = 0; i < 16; i++) begin
            tick();
            es = (slot_pre(cyc) < BLANK) ? G_OFF : eg[slot_idx(cyc)];
            checks++;
            if (An !== exp_an(cyc) || Seg !== es) begin
                failures++;
                $display("[TB] FAIL hex_glyphs cyc=%0d got An=%b Seg=%b expected An=%b Seg=%b",
                         cyc, An, Seg, exp_an(cyc), es);
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [0:6] eg [4];
        logic [0:6] es;
        Lz_En = 1'b1;
        eg = '{G0, G5, G_OFF, G_OFF};
        load_shadow(16'h0050, 4'b0000, 4'b0000);
        for (int i = 0; i < 16; i++) begin
            tick();
            es = (slot_pre(cyc) < BLANK) ? G_OFF : eg[slot_idx(cyc)];
            checks++;
            if (An !== exp_an(cyc) || Seg !== es) begin
                failures++;
                $display("[TB] FAIL lz_0050 cyc=%0d got An=%b Seg=%b expected An=%b Seg=%b",
                         cyc, An, Seg, exp_an(cyc), es);
            end
        end
        eg = '{G0, G_OFF, G_OFF, G_OFF};
        load_shadow(16'h0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 16; i++) begin
            tick();
            es = (slot_pre(cyc) < BLANK) ? G_OFF : eg[slot_idx(cyc)];
            checks++;
            if (An !== exp_an(cyc) || Seg !== es) begin
                failures++;
                $display("[TB] FAIL lz_0000 cyc=%0d got An=%b Seg=%b expected An=%b Seg=%b",
                         cyc, An, Seg, exp_an(cyc), es);
            end
        end
        Lz_En = 1'b0;
    endtask

    task automatic test_ghost_blink();
        logic [0:6] es;
        int         ph;
        int         d;
        load_shadow(16'h8888, 4'b0010, 4'b0001);
        for (int i = 0; i < 64; i++) begin
            tick();
            ph = ((cyc - 1) / (DIV * ND * BF)) % 2;
            d  = slot_idx(cyc);
            if (slot_pre(cyc) < BLANK) es = G_OFF;
            else if (d == 1)           es = G_OFF;
            else if (d == 0 && ph == 1) es = G_OFF;
            else                       es = G8;
            checks++;
            if (An !== exp_an(cyc) || Seg !== es || Frame !== exp_frame(cyc)) begin
                failures++;
                $display("[TB] FAIL ghost_blink cyc=%0d got An=%b Seg=%b Frame=%b expected An=%b Seg=%b Frame=%b",
                         cyc, An, Seg, Frame, exp_an(cyc), es, exp_frame(cyc));
            end
        end
    endtask

    task automatic test_reset_mid_slot();
        logic [0:6] es;
        for (int i = 0; i < 16 && (cyc % 16) != 11; i++) begin
            tick();
        end
        checks++;
        if ((cyc % 16) != 11) begin
            failures++;
            $display("[TB] FAIL mid_slot_align got phase=%0d expected 11", cyc % 16);
        end
        #2;
        Rst = 1'b1;
        #1;
        checks++;
        if (Seg !== G_OFF || An !== 4'b1111 || Frame !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset got Seg=%b An=%b Frame=%b expected Seg=%b An=1111 Frame=0",
                     Seg, An, Frame, G_OFF);
        end
        Ghost = '0;
        Blink = '0;
        tick();
        Rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            es = (slot_pre(cyc) < BLANK) ? G_OFF : G0;
            checks++;
            if (An !== exp_an(cyc) || Seg !== es || Frame !== exp_frame(cyc)) begin
                failures++;
                $display("[TB] FAIL after_reset cyc=%0d got An=%b Seg=%b Frame=%b expected An=%b Seg=%b Frame=%b",
                         cyc, An, Seg, Frame, exp_an(cyc), es, exp_frame(cyc));
            end
        end
    endtask

    task automatic test_load_on_wrap();
        logic [0:6] es;
        load_shadow(16'h1111, 4'b0000, 4'b0000);
        for (int i = 0; i < 4 && (cyc % DIV) != DIV - 1; i++) begin
            tick();
        end
        Digits = 16'h2222;
        Load   = 1'b1;
        tick();
        checks++;
        if (An !== exp_an(cyc) || Seg !== G1) begin
            failures++;
            $display("[TB] FAIL wrap_old_slot cyc=%0d got An=%b Seg=%b expected An=%b Seg=%b",
                     cyc, An, Seg, exp_an(cyc), G1);
        end
        tick();
        Load = 1'b0;
        checks++;
        if (An !== 4'b1111 || Seg !== G_OFF) begin
            failures++;
            $display("[TB] FAIL wrap_dead_time cyc=%0d got An=%b Seg=%b expected An=1111 Seg=%b",
                     cyc, An, Seg, G_OFF);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            es = (slot_pre(cyc) < BLANK) ? G_OFF : G2;
            checks++;
            if (An !== exp_an(cyc) || Seg !== es) begin
                failures++;
                $display("[TB] FAIL wrap_new_value cyc=%0d got An=%b Seg=%b expected An=%b Seg=%b",
                         cyc, An, Seg, exp_an(cyc), es);
            end
        end
    endtask

    initial begin
        Rst = 1'b1; Load = 1'b0; Digits = '0; Ghost = '0; Blink = '0; Lz_En = 1'b0;
        $display("[TB] start");
        test_reset();
        test_hex_glyphs();
        test_leading_zero();
        test_ghost_blink();
        test_reset_mid_slot();
        do_reset();
        test_load_on_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
